div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU.
- Sits in the EX stage beside the ALU. It takes the same two source operands from the ID/EX register and feeds HI/LO write-back through EX/MEM.
- It holds the pipeline via stallreq until the result is valid.
- One quotient bit is produced per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration-counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush (exception/branch kill); aborts the operation in flight.
- start  input  1  request a division; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  WIDTH  rs operand; sampled only on an accepted start.
- divisor  input  WIDTH  rt operand; sampled only on an accepted start.
- busy  output  1  high in CALC.
- ready  output  1  one-cycle pulse; quotient/remainder are valid.
- quotient  output  WIDTH  to LO.
- remainder  output  WIDTH  to HI.
- stallreq  output  1  stall request to the pipeline controller.

Behaviour:
- Reset: resetn low asynchronously forces the following, independent of clk:
  - state = IDLE;
  - busy = ready = 0;
  - quotient = remainder = 0;
  - counter = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 is an accepted start.
  - On acceptance, latch |dividend|, |divisor|, sign flags and signed_div.
  - |x| is the magnitude when signed_div=1 and x[31]=1; otherwise x unchanged.
  - Clear the partial remainder and counter.
  - If divisor==0, go to DONE; otherwise go to CALC.
- CALC, each cycle:
  - shift {rem, quo} left by 1;
  - compute trial = rem_shifted - |divisor| at WIDTH+1 bits;
  - if trial is non-negative, rem = trial and quo[0] = 1; else keep rem and quo[0] = 0;
  - counter increments.
  - After WIDTH iterations (counter == WIDTH-1 on the edge), go to DONE.
- DONE (one cycle):
  - ready=1.
  - quotient/remainder registers load their final values on entry to DONE.
  - Sign fix for signed_div: quotient is negated if the dividend and divisor signs differ; remainder is negated if the dividend was negative.
  - Next state is always IDLE.
  - A start in DONE is not accepted; it is accepted in the following IDLE cycle.
- Divide by zero: DONE is entered one cycle after start with quotient = all ones (32'hFFFFFFFF) and remainder = original dividend, regardless of signed_div.
- Signed overflow: -2^31 / -1 yields quotient 32'h80000000, remainder 0. This falls out of the magnitude path with no special case.
- Latency:
  - start in cycle 0, CALC cycles 1..32, ready in cycle 33.
  - Divide-by-zero: ready in cycle 1.
- stallreq = (state==IDLE & start & ~flush) | (state==CALC).
  - Deasserted in DONE so the consuming instruction advances in the same cycle ready is high.
- Output hold: quotient/remainder hold their values after DONE until the next accepted start reaches DONE. They never change in IDLE or CALC.
- flush:
  - in CALC: return to IDLE on the next edge; no ready pulse; outputs unchanged.
  - in DONE: ready is still driven this cycle; the consumer discards it.
  - flush and start together in IDLE: start is ignored.
- start while busy is ignored; operand changes during CALC have no effect.
- resetn low mid-CALC: immediate IDLE; no ready pulse after release.

Test Plan:
- DIVU 100 / 7 -> ready exactly 33 cycles after start; quotient 14, remainder 2; stallreq high cycles 0–32, low in cycle 33.
- DIV -7 / 2 (32'hFFFFFFF9, 2) -> quotient 32'hFFFFFFFD (-3), remainder 32'hFFFFFFFF (-1).
- DIV 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0; DIVU of the same operands -> quotient 0, remainder 32'h80000000.
- Divisor 0, dividend 32'h12345678 -> ready in cycle 1; quotient 32'hFFFFFFFF, remainder 32'h12345678.
- flush asserted in cycle 10 of CALC -> IDLE next cycle; no ready pulse; outputs keep the prior result. A new start 1 cycle later completes normally (DIVU 9/3 -> 3, 0).
- resetn pulsed low mid-CALC (asynchronously, between edges) -> busy/ready/quotient/remainder go to 0 immediately; start held high throughout the operation is accepted only when IDLE is re-entered.

Source files
------------

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Purpose  : EX-stage divider request/response bundle (operands in, HI/LO out).
//  Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             stallreq;

    modport master (
        output flush, start, signed_div, dividend, divisor,
        input  busy, ready, quotient, remainder, stallreq
    );

    modport slave (
        input  flush, start, signed_div, dividend, divisor,
        output busy, ready, quotient, remainder, stallreq
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative radix-2 restoring divider for DIV/DIVU, one bit/cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      resetn,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_ready;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.flush;
    assign w_dvd_neg = bus.signed_div & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.signed_div & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? -bus.divisor : bus.divisor;

    // The dividend magnitude lives in r_quo and is shifted out MSB-first
    // into the partial remainder while quotient bits shift in at the LSB.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quo   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        if (bus.divisor == '0) begin
                            // Divide by zero reports the raw dividend, never its magnitude.
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_ready     <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_iter) begin
                            r_quotient  <= r_neg_q ? -w_quo_next : w_quo_next;
                            r_remainder <= r_neg_r ? -w_rem_next : w_rem_next;
                            r_ready     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.ready     = r_ready;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.stallreq  = w_accept | (r_state == S_CALC);
endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Directed self-checking bench for div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_unit_if #(.WIDTH(32)) u_if ();

    div_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if.slave)
    );

    always #5 clk = ~clk;

    // Issues one start at a negedge, then counts cycles to ready.
    // Operands are scrambled after acceptance; they must have no effect.
    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stall_err);
        lat       = -1;
        stall_err = 0;
        @(negedge clk);
        u_if.start      = 1'b1;
        u_if.signed_div = sd;
        u_if.dividend   = a;
        u_if.divisor    = b;
        #1;
        if (u_if.stallreq !== 1'b1) stall_err++;
        @(posedge clk);
        #1;
        u_if.start    = 1'b0;
        u_if.dividend = 32'hDEADBEEF;
        u_if.divisor  = 32'h00000000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (u_if.ready === 1'b1) begin
                lat = c;
                if (u_if.stallreq !== 1'b0) stall_err++;
                break;
            end else if (u_if.stallreq !== 1'b1) begin
                stall_err++;
            end
        end
    endtask

    task automatic test_reset();
        u_if.start = 1'b0; u_if.flush = 1'b0; u_if.signed_div = 1'b0;
        u_if.dividend = '0; u_if.divisor = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", u_if.busy); end
        n_tests++; if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", u_if.ready); end
        n_tests++; if (u_if.quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quo: got %h expected 0", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'h0) begin n_fail++; $display("FAIL reset_rem: got %h expected 0", u_if.remainder); end
        resetn = 1'b1;
        @(negedge clk);
        n_tests++; if (u_if.stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", u_if.stallreq); end
    endtask

    task automatic test_divu_basic();
        int lat, se;
        run_op(1'b0, 32'd100, 32'd7, lat, se);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        n_tests++; if (se !== 0) begin n_fail++; $display("FAIL divu_stallreq: got %0d bad cycles expected 0", se); end
        n_tests++; if (u_if.quotient !== 32'd14) begin n_fail++; $display("FAIL divu_quo: got %h expected %h", u_if.quotient, 32'd14); end
        n_tests++; if (u_if.remainder !== 32'd2) begin n_fail++; $display("FAIL divu_rem: got %h expected %h", u_if.remainder, 32'd2); end
        @(negedge clk);
        n_tests++; if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL divu_ready_pulse: got %b expected 0", u_if.ready); end
        n_tests++; if (u_if.quotient !== 32'd14) begin n_fail++; $display("FAIL divu_quo_hold: got %h expected %h", u_if.quotient, 32'd14); end
    endtask

    task automatic test_div_signed();
        int lat, se;
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, se);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL sdiv_latency: got %0d expected 33", lat); end
        n_tests++; if (u_if.quotient !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL sdiv_quo: got %h expected fffffffd", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sdiv_rem: got %h expected ffffffff", u_if.remainder); end
        // 100 / -7 = -14 rem 2 (remainder follows the dividend sign)
        run_op(1'b1, 32'd100, 32'hFFFFFFF9, lat, se);
        n_tests++; if (u_if.quotient !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL sdiv2_quo: got %h expected fffffff2", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'd2) begin n_fail++; $display("FAIL sdiv2_rem: got %h expected 00000002", u_if.remainder); end
    endtask

    task automatic test_overflow();
        int lat, se;
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, se);
        n_tests++; if (u_if.quotient !== 32'h80000000) begin n_fail++; $display("FAIL ovf_quo: got %h expected 80000000", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'h0) begin n_fail++; $display("FAIL ovf_rem: got %h expected 0", u_if.remainder); end
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, se);
        n_tests++; if (u_if.quotient !== 32'h0) begin n_fail++; $display("FAIL ovf_u_quo: got %h expected 0", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'h80000000) begin n_fail++; $display("FAIL ovf_u_rem: got %h expected 80000000", u_if.remainder); end
    endtask

    task automatic test_div_zero();
        int lat, se;
        run_op(1'b1, 32'hFFFFFFFB, 32'h0, lat, se);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL dz_signed_latency: got %0d expected 1", lat); end
        n_tests++; if (u_if.quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_signed_quo: got %h expected ffffffff", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL dz_signed_rem: got %h expected fffffffb", u_if.remainder); end
        run_op(1'b0, 32'h12345678, 32'h0, lat, se);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        n_tests++; if (se !== 0) begin n_fail++; $display("FAIL dz_stallreq: got %0d bad cycles expected 0", se); end
        n_tests++; if (u_if.quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_quo: got %h expected ffffffff", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'h12345678) begin n_fail++; $display("FAIL dz_rem: got %h expected 12345678", u_if.remainder); end
    endtask

    task automatic test_flush();
        int lat, se;
        @(negedge clk);
        u_if.start = 1'b1; u_if.signed_div = 1'b0;
        u_if.dividend = 32'd1000; u_if.divisor = 32'd10;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", u_if.busy); end
        u_if.flush = 1'b1;
        @(posedge clk);
        #1 u_if.flush = 1'b0;
        @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b expected 0", u_if.busy); end
        n_tests++; if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL flush_no_ready: got %b expected 0", u_if.ready); end
        n_tests++; if (u_if.stallreq !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", u_if.stallreq); end
        n_tests++; if (u_if.quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL flush_quo_hold: got %h expected ffffffff", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'h12345678) begin n_fail++; $display("FAIL flush_rem_hold: got %h expected 12345678", u_if.remainder); end
        run_op(1'b0, 32'd9, 32'd3, lat, se);
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL flush_new_latency: got %0d expected 33", lat); end
        n_tests++; if (u_if.quotient !== 32'd3) begin n_fail++; $display("FAIL flush_new_quo: got %h expected 3", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'd0) begin n_fail++; $display("FAIL flush_new_rem: got %h expected 0", u_if.remainder); end
    endtask

    task automatic test_start_flush_idle();
        @(negedge clk);
        u_if.start = 1'b1; u_if.flush = 1'b1; u_if.signed_div = 1'b0;
        u_if.dividend = 32'd50; u_if.divisor = 32'd5;
        #1;
        n_tests++; if (u_if.stallreq !== 1'b0) begin n_fail++; $display("FAIL idle_flush_stall: got %b expected 0", u_if.stallreq); end
        @(posedge clk);
        #1 begin u_if.start = 1'b0; u_if.flush = 1'b0; end
        @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL idle_flush_busy: got %b expected 0", u_if.busy); end
    endtask

    task automatic test_async_reset();
        int  lat;
        bit  early_ready;
        @(negedge clk);
        u_if.start = 1'b1; u_if.signed_div = 1'b0;
        u_if.dividend = 32'd9; u_if.divisor = 32'd3;
        repeat (5) @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before: got %b expected 1", u_if.busy); end
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", u_if.busy); end
        n_tests++; if (u_if.ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b expected 0", u_if.ready); end
        n_tests++; if (u_if.quotient !== 32'h0) begin n_fail++; $display("FAIL arst_quo: got %h expected 0", u_if.quotient); end
        n_tests++; if (u_if.remainder !== 32'h0) begin n_fail++; $display("FAIL arst_rem: got %h expected 0", u_if.remainder); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        n_tests++; if (u_if.stallreq !== 1'b1) begin n_fail++; $display("FAIL arst_reaccept_stall: got %b expected 1", u_if.stallreq); end
        lat = -1;
        early_ready = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (u_if.ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL arst_latency: got %0d expected 33", lat); end
        n_tests++; if (u_if.quotient !== 32'd3) begin n_fail++; $display("FAIL arst_quo_done: got %h expected 3", u_if.quotient); end
        n_tests++; if (u_if.stallreq !== 1'b0) begin n_fail++; $display("FAIL arst_done_stall: got %b expected 0", u_if.stallreq); end
        @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle_busy: got %b expected 0", u_if.busy); end
        n_tests++; if (u_if.stallreq !== 1'b1) begin n_fail++; $display("FAIL arst_idle_stall: got %b expected 1", u_if.stallreq); end
        @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL arst_second_accept: got %b expected 1", u_if.busy); end
        u_if.start = 1'b0;
        u_if.flush = 1'b1;
        @(posedge clk);
        #1 u_if.flush = 1'b0;
        @(negedge clk);
        n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL arst_final_flush: got %b expected 0", u_if.busy); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_overflow();
        test_div_zero();
        test_flush();
        test_start_flush_idle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
